// File: rtl/fwrisc_uart_prog_pkg.sv
// fwrisc_uart_prog_pkg: shared FSM state type and UART frame constants for the program sender.
package fwrisc_uart_prog_pkg;
   typedef enum logic [3:0] {
      IDLE, FETCH, LOAD, START_BIT, DATA, STOP_BIT, WAIT_ACK, FINISH, ERROR
   } prog_tx_state_e;
   localparam int UART_DATA_BITS = 8;
   localparam int UART_STOP_BITS = 1;
   localparam int BIT_IDX_W = $clog2(UART_DATA_BITS + UART_STOP_BITS + 1);
endpackage

// File: rtl/fwrisc_uart_tx_serializer.sv
// fwrisc_uart_tx_serializer: 8N1 LSB-first frame shifter; bit_idx 0 is the start bit,
// 1..UART_DATA_BITS the data bits, the remainder stop bits.
module fwrisc_uart_tx_serializer
   import fwrisc_uart_prog_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      load,
   input  logic [UART_DATA_BITS-1:0] data,
   output logic                      tx,
   output logic                      busy,
   output logic [BIT_IDX_W-1:0]      bit_idx
);
   localparam logic [BIT_IDX_W-1:0] LAST = BIT_IDX_W'(UART_DATA_BITS + UART_STOP_BITS);
   logic [15:0] baud;
   logic [UART_DATA_BITS-1:0] sh;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tx      <= 1'b1;
         busy    <= 1'b0;
         baud    <= '0;
         bit_idx <= '0;
         sh      <= '1;
      end else if (!busy) begin
         if (load) begin
            tx      <= 1'b0;
            busy    <= 1'b1;
            baud    <= '0;
            bit_idx <= '0;
            sh      <= data;
         end
      end else if (baud != 16'(CLKS_PER_BIT - 1)) begin
         baud <= baud + 16'd1;
      end else begin
         baud <= '0;
         // ones shifted in behind the data become the stop bits
         if (bit_idx == LAST) busy <= 1'b0;
         else begin
            tx      <= sh[0];
            sh      <= {1'b1, sh[UART_DATA_BITS-1:1]};
            bit_idx <= bit_idx + BIT_IDX_W'(1);
         end
      end
   end
endmodule

// File: rtl/fwrisc_uart_prog_sender.sv
// fwrisc_uart_prog_sender: ack-paced UART boot streamer of a program image from byte memory.
// Define PROG_SENDER_CKSUM_EN to append a modulo-256 checksum frame after the image.
module fwrisc_uart_prog_sender
   import fwrisc_uart_prog_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int MEM_AW       = 12,
   parameter int ACK_TIMEOUT  = 1_000_000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [MEM_AW:0]   length,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   input  logic              ack,
   output logic              tx,
   output logic              busy,
   output logic              done,
   output logic              timeout_err,
   output logic [MEM_AW:0]   byte_cnt
);
   localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
   prog_tx_state_e state;
   logic [MEM_AW:0] len_q, cnt_nxt;
   logic [TO_W-1:0] to_cnt;
   logic ack_s1, ack_s2, ack_d, ack_edge;
   logic ser_busy;
   logic [BIT_IDX_W-1:0] ser_idx;
   logic [7:0] ser_data;
   assign cnt_nxt = byte_cnt + (MEM_AW + 1)'(1);
`ifdef PROG_SENDER_CKSUM_EN
   logic [7:0] sum;
   logic cks;
   assign ser_data = cks ? sum : mem_rdata;
`else
   assign ser_data = mem_rdata;
`endif
   fwrisc_uart_tx_serializer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
      .clock(clock), .reset(reset), .load(state == LOAD), .data(ser_data),
      .tx(tx), .busy(ser_busy), .bit_idx(ser_idx)
   );
   // edge detector runs in every state so a level held across a frame is never a new edge
   always_ff @(posedge clock or posedge reset) begin
      if (reset) {ack_s1, ack_s2, ack_d, ack_edge} <= '0;
      else begin
         ack_s1   <= ack;
         ack_s2   <= ack_s1;
         ack_d    <= ack_s2;
         ack_edge <= ack_s2 & ~ack_d;
      end
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         byte_cnt    <= '0;
         mem_addr    <= '0;
         len_q       <= '0;
         to_cnt      <= '0;
`ifdef PROG_SENDER_CKSUM_EN
         sum         <= '0;
         cks         <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               len_q       <= length;
               byte_cnt    <= '0;
               mem_addr    <= '0;
               timeout_err <= 1'b0;
               busy        <= 1'b1;
               state       <= (length == '0) ? FINISH : FETCH;
`ifdef PROG_SENDER_CKSUM_EN
               sum         <= '0;
               cks         <= 1'b0;
`endif
            end
            FETCH: state <= LOAD;
            LOAD: begin
               state <= START_BIT;
`ifdef PROG_SENDER_CKSUM_EN
               if (!cks) sum <= sum + mem_rdata;
`endif
            end
            START_BIT: if (ser_idx != '0) state <= DATA;
            DATA: if (ser_idx == BIT_IDX_W'(UART_DATA_BITS + 1)) state <= STOP_BIT;
            STOP_BIT: if (!ser_busy) begin
               state  <= WAIT_ACK;
               to_cnt <= '0;
            end
            WAIT_ACK: begin
               if (ack_edge) begin
`ifdef PROG_SENDER_CKSUM_EN
                  if (cks) state <= FINISH;
                  else begin
                     byte_cnt <= cnt_nxt;
                     mem_addr <= mem_addr + MEM_AW'(1);
                     cks      <= (cnt_nxt == len_q);
                     state    <= (cnt_nxt == len_q) ? LOAD : FETCH;
                  end
`else
                  byte_cnt <= cnt_nxt;
                  mem_addr <= mem_addr + MEM_AW'(1);
                  state    <= (cnt_nxt == len_q) ? FINISH : FETCH;
`endif
               end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) state <= ERROR;
               else to_cnt <= to_cnt + TO_W'(1);
            end
            FINISH: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            ERROR: begin
               timeout_err <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fwrisc_uart_prog_sender.sv
// tb_fwrisc_uart_prog_sender: directed scenarios for the UART program sender (default build).
module tb_fwrisc_uart_prog_sender;
   localparam int CPB = 4;
   localparam int AW  = 4;
   localparam int TO  = 50;
   logic clock = 1'b0, reset = 1'b1, start = 1'b0, ack = 1'b0;
   logic [AW:0] length = '0;
   logic [AW-1:0] mem_addr;
   logic [7:0] mem_rdata;
   logic tx, busy, done, timeout_err;
   logic [AW:0] byte_cnt;
   logic [7:0] mem [16];
   logic [7:0] rx_q [$];
   int checks = 0, errors = 0, done_cnt = 0, done_busy_bad = 0, stop_bad = 0;

   fwrisc_uart_prog_sender #(.CLKS_PER_BIT(CPB), .MEM_AW(AW), .ACK_TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset), .start(start), .length(length), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .ack(ack), .tx(tx), .busy(busy), .done(done),
      .timeout_err(timeout_err), .byte_cnt(byte_cnt)
   );

   always #5 clock = ~clock;
   always @(posedge clock) mem_rdata <= mem[mem_addr];
   always @(negedge clock) if (done === 1'b1) begin
      done_cnt++;
      if (busy !== 1'b0) done_busy_bad++;
   end

   // frame decoder: first low sample is in the start bit, then one sample per bit period
   initial begin : rx_mon
      logic [7:0] b;
      forever begin
         @(negedge clock);
         if (tx === 1'b0) begin
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clock);
               b[i] = tx;
            end
            repeat (CPB) @(negedge clock);
            if (tx !== 1'b1) stop_bad++;
            rx_q.push_back(b);
         end
      end
   end

   task automatic pulse_start(input logic [AW:0] len);
      length = len;
      start  = 1'b1;
      @(negedge clock);
      start  = 1'b0;
   endtask

   task automatic pulse_ack;
      ack = 1'b1;
      repeat (4) @(negedge clock);
      ack = 1'b0;
   endtask

   task automatic wait_frame(output logic [7:0] d, output bit ok);
      ok = 1'b0;
      d  = 'x;
      for (int i = 0; i < 400; i++) begin
         if (rx_q.size() != 0) break;
         @(negedge clock);
      end
      if (rx_q.size() != 0) begin
         d  = rx_q.pop_front();
         ok = 1'b1;
      end
   endtask

   task automatic flush;
      repeat (60) @(negedge clock);
      rx_q.delete();
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr got %b exp 0", timeout_err); end
      checks++; if (byte_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", byte_cnt); end
      checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr got %0d exp 0", mem_addr); end
   endtask

   task automatic test_stream;
      logic [7:0] exp [3];
      logic [7:0] d;
      bit ok;
      int d0;
      exp = '{8'hA5, 8'h3C, 8'hFF};
      for (int i = 0; i < 3; i++) mem[i] = exp[i];
      d0 = done_cnt;
      pulse_start(3);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stream_busy_rise got %b exp 1", busy); end
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL stream_tx_c1 got %b exp 1", tx); end
      @(negedge clock);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL stream_tx_c2 got %b exp 1", tx); end
      @(negedge clock);
      checks++; if (tx !== 1'b0) begin errors++; $display("FAIL stream_tx_c3 got %b exp 0", tx); end
      for (int i = 0; i < 3; i++) begin
         wait_frame(d, ok);
         checks++; if (!ok || d !== exp[i]) begin errors++; $display("FAIL stream_frame%0d got %h exp %h", i, d, exp[i]); end
         repeat (20) @(negedge clock);
         pulse_ack();
         repeat (4) @(negedge clock);
         checks++; if (byte_cnt !== (AW+1)'(i + 1)) begin errors++; $display("FAIL stream_cnt%0d got %0d exp %0d", i, byte_cnt, i + 1); end
      end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL stream_done got %0d exp 1", done_cnt - d0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_busy_end got %b exp 0", busy); end
      checks++; if (mem_addr !== AW'(3)) begin errors++; $display("FAIL stream_addr got %0d exp 3", mem_addr); end
      checks++; if (done_busy_bad != 0) begin errors++; $display("FAIL stream_done_busy got %0d exp 0", done_busy_bad); end
      checks++; if (stop_bad != 0) begin errors++; $display("FAIL stream_stop got %0d exp 0", stop_bad); end
   endtask

   task automatic test_len_zero;
      int d0;
      d0 = done_cnt;
      pulse_start(0);
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL zero_c1 busy %b done %b exp 1 0", busy, done); end
      @(negedge clock);
      checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL zero_c2 busy %b done %b exp 0 1", busy, done); end
      @(negedge clock);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_c3 done %b exp 0", done); end
      repeat (10) @(negedge clock);
      checks++; if (rx_q.size() != 0 || tx !== 1'b1) begin errors++; $display("FAIL zero_tx frames %0d tx %b exp 0 1", rx_q.size(), tx); end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL zero_done got %0d exp 1", done_cnt - d0); end
   endtask

   task automatic test_timeout;
      int d0;
      d0 = done_cnt;
      pulse_start(2);
      repeat (89) @(negedge clock);
      checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_early terr %b busy %b exp 0 1", timeout_err, busy); end
      repeat (10) @(negedge clock);
      checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_terr got %b exp 1", timeout_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy got %b exp 0", busy); end
      checks++; if (byte_cnt !== '0) begin errors++; $display("FAIL to_cnt got %0d exp 0", byte_cnt); end
      checks++; if (done_cnt != d0) begin errors++; $display("FAIL to_done got %0d exp 0", done_cnt - d0); end
      flush();
      pulse_start(0);
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear got %b exp 0", timeout_err); end
      repeat (3) @(negedge clock);
   endtask

   task automatic test_spurious;
      logic [7:0] d;
      bit ok;
      int d0;
      mem[0] = 8'h5A;
      mem[1] = 8'hC3;
      d0 = done_cnt;
      pulse_start(2);
      repeat (4) @(negedge clock);
      pulse_start(1);
      repeat (14) @(negedge clock);
      pulse_ack();
      wait_frame(d, ok);
      checks++; if (!ok || d !== 8'h5A) begin errors++; $display("FAIL spur_frame0 got %h exp 5a", d); end
      repeat (10) @(negedge clock);
      checks++; if (byte_cnt !== '0) begin errors++; $display("FAIL spur_cnt0 got %0d exp 0", byte_cnt); end
      ack = 1'b1;
      repeat (8) @(negedge clock);
      checks++; if (byte_cnt !== (AW+1)'(1)) begin errors++; $display("FAIL spur_cnt1 got %0d exp 1", byte_cnt); end
      wait_frame(d, ok);
      checks++; if (!ok || d !== 8'hC3) begin errors++; $display("FAIL spur_frame1 got %h exp c3", d); end
      repeat (20) @(negedge clock);
      checks++; if (byte_cnt !== (AW+1)'(1) || done_cnt != d0) begin errors++; $display("FAIL spur_held cnt %0d done %0d exp 1 0", byte_cnt, done_cnt - d0); end
      ack = 1'b0;
      repeat (4) @(negedge clock);
      ack = 1'b1;
      repeat (8) @(negedge clock);
      checks++; if (byte_cnt !== (AW+1)'(2)) begin errors++; $display("FAIL spur_cnt2 got %0d exp 2", byte_cnt); end
      checks++; if (done_cnt - d0 != 1 || busy !== 1'b0) begin errors++; $display("FAIL spur_done done %0d busy %b exp 1 0", done_cnt - d0, busy); end
      ack = 1'b0;
      repeat (4) @(negedge clock);
   endtask

   task automatic test_reset_mid;
      logic [7:0] d;
      bit ok;
      mem[0] = 8'h96;
      mem[1] = 8'h0F;
      mem[2] = 8'h33;
      pulse_start(3);
      wait_frame(d, ok);
      checks++; if (!ok || d !== 8'h96) begin errors++; $display("FAIL rst_frame0 got %h exp 96", d); end
      repeat (20) @(negedge clock);
      pulse_ack();
      repeat (20) @(negedge clock);
      reset = 1'b1;
      #1;
      checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_async tx %b busy %b exp 1 0", tx, busy); end
      checks++; if (mem_addr !== '0 || byte_cnt !== '0) begin errors++; $display("FAIL rst_regs addr %0d cnt %0d exp 0 0", mem_addr, byte_cnt); end
      @(negedge clock);
      reset = 1'b0;
      flush();
      pulse_start(1);
      wait_frame(d, ok);
      checks++; if (!ok || d !== 8'h96) begin errors++; $display("FAIL rst_fresh got %h exp 96", d); end
      repeat (20) @(negedge clock);
      pulse_ack();
      repeat (4) @(negedge clock);
      checks++; if (byte_cnt !== (AW+1)'(1) || busy !== 1'b0) begin errors++; $display("FAIL rst_end cnt %0d busy %b exp 1 0", byte_cnt, busy); end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17);
      test_reset();
      test_stream();
      test_len_zero();
      test_timeout();
      test_spurious();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
